// File: rtl/power_governor_if.sv
// power_governor_if
//   Bundles the request, feedback and drive signals between the governor,
//   its requester and the Power block.
//   master : the side that issues requests and feeds back the power level
//            (drives en, reqValid, reqSetting, powerLevel, powerWarn).
//   slave  : the governor itself (drives powerSetting, powerMode, govState,
//            brownout, brownoutCount).
interface power_governor_if;
    logic       en;
    logic       reqValid;
    logic [1:0] reqSetting;
    logic [7:0] powerLevel;
    logic       powerWarn;
    logic [1:0] powerSetting;
    logic       powerMode;
    logic [1:0] govState;
    logic       brownout;
    logic [7:0] brownoutCount;

    modport master (
        output en, reqValid, reqSetting, powerLevel, powerWarn,
        input  powerSetting, powerMode, govState, brownout, brownoutCount
    );

    modport slave (
        input  en, reqValid, reqSetting, powerLevel, powerWarn,
        output powerSetting, powerMode, govState, brownout, brownoutCount
    );
endinterface

// File: rtl/power_governor.sv
// power_governor
//   Control stage in front of the Power block. Arbitrates user power requests
//   against the fed-back level and warn flag, produces the powerSetting /
//   powerMode pair for Power, and counts brownout events (saturating).
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - power_governor_if.slave
//              in : en, reqValid, reqSetting[1:0], powerLevel[7:0], powerWarn
//              out: powerSetting[1:0], powerMode, govState[1:0],
//                   brownout, brownoutCount[7:0]
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no request latched, Power recharging at setting 0
//   ACTIVE   | serving the latched request
//   THROTTLE | low power warning, serving at setting 1 while dwell runs
//   RECHARGE | forced recharge until the level climbs past the resume mark
module power_governor #(
    parameter int         RESUME_LEVEL     = 120,
    parameter int         FULL_LEVEL       = 179,
    parameter int         THROTTLE_CYCLES  = 8,
    parameter logic [1:0] RECHARGE_SETTING = 2'd3
) (
    input  logic clk,
    input  logic rst,
    power_governor_if.slave bus
);

    localparam int         DW          = (THROTTLE_CYCLES > 1) ? $clog2(THROTTLE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(THROTTLE_CYCLES - 1);
    localparam logic [7:0] RESUME_LVL  = 8'(RESUME_LEVEL);
    localparam logic [7:0] FULL_LVL    = 8'(FULL_LEVEL);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        THROTTLE = 2'd2,
        RECHARGE = 2'd3
    } govState_e;

    govState_e     stateQ, stateNext;
    logic [1:0]    reqLatched;
    logic [DW-1:0] dwellQ, dwellNext;
    logic          brownoutQ, pulseNext;
    logic [7:0]    countQ;

    always_comb begin
        stateNext = stateQ;
        dwellNext = dwellQ;
        pulseNext = 1'b0;
        case (stateQ)
            IDLE: begin
                if (reqLatched != 2'd0)
                    stateNext = bus.powerWarn ? RECHARGE : ACTIVE;
            end
            ACTIVE: begin
                if (reqLatched == 2'd0) begin
                    stateNext = IDLE;
                end else if (bus.powerWarn) begin
                    stateNext = THROTTLE;
                    dwellNext = DWELL_LOAD;
                end
            end
            THROTTLE: begin
                if (reqLatched == 2'd0) begin
                    stateNext = IDLE;
                end else if (bus.powerLevel == 8'd0 || dwellQ == '0) begin
                    stateNext = RECHARGE;
                    pulseNext = 1'b1;
                end else begin
                    dwellNext = dwellQ - DW'(1);
                end
            end
            RECHARGE: begin
                // FULL_LEVEL is an unconditional exit even if someone sets it
                // below RESUME_LEVEL.
                if (bus.powerLevel >= FULL_LVL || bus.powerLevel >= RESUME_LVL)
                    stateNext = (reqLatched != 2'd0) ? ACTIVE : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.powerMode    = 1'b0;
        bus.powerSetting = 2'd0;
        case (stateQ)
            ACTIVE: begin
                bus.powerMode    = 1'b1;
                bus.powerSetting = reqLatched;
            end
            THROTTLE: begin
                bus.powerMode    = 1'b1;
                bus.powerSetting = 2'd1;
            end
            RECHARGE: begin
                bus.powerMode    = 1'b0;
                bus.powerSetting = RECHARGE_SETTING;
            end
            default: begin
                bus.powerMode    = 1'b0;
                bus.powerSetting = 2'd0;
            end
        endcase
    end

    assign bus.govState      = stateQ;
    assign bus.brownout      = brownoutQ;
    assign bus.brownoutCount = countQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= IDLE;
            reqLatched <= 2'd0;
            dwellQ     <= '0;
            brownoutQ  <= 1'b0;
            countQ     <= 8'd0;
        end else if (bus.en) begin
            stateQ    <= stateNext;
            dwellQ    <= dwellNext;
            brownoutQ <= pulseNext;
            if (pulseNext && countQ != 8'hFF)
                countQ <= countQ + 8'd1;
            // The FSM above used the old reqLatched, so a request lands one
            // edge later.
            if (bus.reqValid)
                reqLatched <= bus.reqSetting;
        end else begin
            // Pulse never stretches across a stalled edge.
            brownoutQ <= 1'b0;
        end
    end

endmodule

// File: doc/power_governor.md
Name: power_governor

Overview:
- Control stage directly upstream of the Power block.
- Arbitrates user power requests against the fed-back power level and warn flag. Generates the powerSetting/powerMode pair that drives Power.
- Runs a four-state FSM: idle, serve, throttle on low power, forced recharge with hysteresis. Also keeps a saturating brownout event counter.

Parameters:
- RESUME_LEVEL, 120, powerLevel at or above which a forced recharge ends.
- FULL_LEVEL, 179, powerLevel at or above which recharge ends unconditionally. Matches the Power block ceiling.
- THROTTLE_CYCLES, 8, number of enabled cycles spent in THROTTLE before forced recharge.
- RECHARGE_SETTING, 2'd3, powerSetting value driven while in RECHARGE.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  clock qualifier; when 0 all registers hold.
- reqValid  in  1  request strobe; reqSetting is sampled when reqValid=1 and en=1.
- reqSetting  in  2  requested usage level: 0 = stop, 1/2/3 = low/moderate/high.
- powerLevel  in  8  current level fed back from Power powerOutput (seconds).
- powerWarn  in  1  low-level flag fed back from Power.
- powerSetting  out  2  setting to Power.
- powerMode  out  1  mode to Power: 0 = recharging, 1 = using.
- govState  out  2  FSM state: 0 = IDLE, 1 = ACTIVE, 2 = THROTTLE, 3 = RECHARGE.
- brownout  out  1  one-cycle pulse on the THROTTLE->RECHARGE transition.
- brownoutCount  out  8  count of brownout events; saturates at 255.

Behaviour:
- Reset (async, rst=1): govState=IDLE, reqLatched=0, dwell counter=0, brownout=0, brownoutCount=0. Outputs therefore powerSetting=0, powerMode=0.
- en=0: every register holds, brownout forced 0, no transitions. Requests are ignored.
- Request latch: on an edge with en=1 and reqValid=1, reqLatched<=reqSetting. The FSM evaluates the old reqLatched at that edge, so a request takes effect one edge later.
- Output decode (pure function of the state register and reqLatched):
  - IDLE: powerMode=0, powerSetting=0.
  - ACTIVE: powerMode=1, powerSetting=reqLatched.
  - THROTTLE: powerMode=1, powerSetting=1.
  - RECHARGE: powerMode=0, powerSetting=RECHARGE_SETTING.
- FSM transitions, evaluated at each enabled edge, listed in priority order:
  - IDLE:
    - reqLatched!=0 and powerWarn=0 -> ACTIVE.
    - reqLatched!=0 and powerWarn=1 -> RECHARGE (no brownout pulse).
    - Otherwise stay.
  - ACTIVE:
    - reqLatched==0 -> IDLE.
    - powerWarn=1 -> THROTTLE, with the dwell counter loaded to THROTTLE_CYCLES-1.
    - Otherwise stay.
  - THROTTLE:
    - reqLatched==0 -> IDLE.
    - powerLevel==0 or dwell counter==0 -> RECHARGE, brownout=1 for the next cycle, brownoutCount+1 (saturating).
    - Otherwise the dwell counter decrements.
  - RECHARGE:
    - powerLevel>=FULL_LEVEL or powerLevel>=RESUME_LEVEL -> ACTIVE if reqLatched!=0, else IDLE.
    - Otherwise stay. Requests, including stop, are latched but not served.
- Simultaneous events:
  - Stop outranks warn in ACTIVE/THROTTLE.
  - Warn outranks a new reqSetting in the same cycle (the new setting is latched and used later).
- THROTTLE exits only via stop or recharge, never directly back to ACTIVE, even if powerWarn clears.
- brownoutCount at 255 stays 255. brownout still pulses.
- Reset mid-operation, any state: immediate return to reset values, independent of clk and en.
- govState encoding is fixed as listed. No illegal states are reachable. Any unreachable encoding must decode to IDLE outputs and go to IDLE at the next enabled edge.

Test Plan:
- Reset then idle: assert rst mid-cycle while in ACTIVE -> immediately govState=0, powerSetting=0, powerMode=0, brownoutCount=0.
- Serve request: powerLevel=100, powerWarn=0, reqValid=1/reqSetting=3 at edge N -> govState=1, powerSetting=3, powerMode=1 after edge N+1. Then reqSetting=0 -> IDLE one edge after the latch edge.
- Throttle and brownout: in ACTIVE with reqSetting=2, raise powerWarn and hold powerLevel=40 -> THROTTLE (powerSetting=1) for exactly 8 enabled edges, then RECHARGE with powerMode=0, powerSetting=3, a one-cycle brownout pulse, brownoutCount=1.
- Early exhaustion: in THROTTLE, drive powerLevel=0 on the 3rd cycle -> RECHARGE at that edge, brownout pulse.
- Hysteresis: in RECHARGE, step powerLevel 119 -> stay; 120 with reqLatched=2 -> ACTIVE, powerSetting=2. Repeat with reqLatched=0 -> IDLE.
- en gating and saturation:
  - Hold en=0 for 5 cycles in THROTTLE -> dwell counter and state frozen, reqValid ignored.
  - Force 256 brownouts -> brownoutCount=255.
